// File: rtl/alpha_arbiter_pkg.sv
// alpha_arbiter_pkg: shared widths and state encoding for the alpha finder arbiter
package alpha_arbiter_pkg;
  typedef enum logic [0:0] {IDLE, SEND} state_t;
  function automatic int final_width(input int data_width, input int block_size_log);
    return data_width * 2 + 2 + block_size_log;
  endfunction
  function automatic int tag_w(input int num_req);
    return num_req > 1 ? $clog2(num_req) : 1;
  endfunction
endpackage

// File: rtl/alpha_tag_fifo.sv
// alpha_tag_fifo: synchronous FIFO holding grant tags in issue order
module alpha_tag_fifo #(
  parameter int W = 1,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/alpha_finder_arbiter.sv
// alpha_finder_arbiter: round-robin sharing of one alpha_finder with in-order result routing
module alpha_finder_arbiter
  import alpha_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BLOCK_SIZE_LOG = 8,
  parameter int ALPHA_WIDTH = 10,
  parameter int NUM_REQ = 2,
  parameter int TAG_DEPTH = 4,
  localparam int FINAL_WIDTH = final_width(DATA_WIDTH, BLOCK_SIZE_LOG)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ*FINAL_WIDTH-1:0] req_alphan_data,
  input  logic [NUM_REQ-1:0]             req_alphan_valid,
  output logic [NUM_REQ-1:0]             req_alphan_ready,
  input  logic [NUM_REQ*FINAL_WIDTH-1:0] req_alphad_data,
  input  logic [NUM_REQ-1:0]             req_alphad_valid,
  output logic [NUM_REQ-1:0]             req_alphad_ready,
  output logic [ALPHA_WIDTH-1:0]         req_alpha_data,
  output logic [NUM_REQ-1:0]             req_alpha_valid,
  input  logic [NUM_REQ-1:0]             req_alpha_ready,
  output logic [FINAL_WIDTH-1:0]         finder_alphan_data,
  output logic                           finder_alphan_valid,
  input  logic                           finder_alphan_ready,
  output logic [FINAL_WIDTH-1:0]         finder_alphad_data,
  output logic                           finder_alphad_valid,
  input  logic                           finder_alphad_ready,
  input  logic [ALPHA_WIDTH-1:0]         finder_output_data,
  input  logic                           finder_output_valid,
  output logic                           finder_output_ready
);
  localparam int TW = tag_w(NUM_REQ);
  localparam int CW = $clog2(TAG_DEPTH) + 1;
  state_t state;
  logic [TW-1:0] g, rr_ptr, sel, head;
  logic an_sent, ad_sent, an_hs, ad_hs, an_done, ad_done, grant, out_hs, tag_full, tag_empty;
  logic [CW-1:0] tag_count;
  logic [NUM_REQ-1:0] elig;
  assign elig = req_alphan_valid & req_alphad_valid;
  always_comb begin
    sel = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (elig[(int'(rr_ptr) + k) % NUM_REQ]) sel = TW'((int'(rr_ptr) + k) % NUM_REQ);
  end
  assign grant = state == IDLE && |elig && !tag_full && tag_count < CW'(TAG_DEPTH);
  assign finder_alphan_valid = state == SEND && !an_sent;
  assign finder_alphad_valid = state == SEND && !ad_sent;
  assign finder_alphan_data = req_alphan_data[g*FINAL_WIDTH +: FINAL_WIDTH];
  assign finder_alphad_data = req_alphad_data[g*FINAL_WIDTH +: FINAL_WIDTH];
  assign an_hs = finder_alphan_valid && finder_alphan_ready;
  assign ad_hs = finder_alphad_valid && finder_alphad_ready;
  assign an_done = an_sent || an_hs;
  assign ad_done = ad_sent || ad_hs;
  assign req_alphan_ready = NUM_REQ'(an_hs) << g;
  assign req_alphad_ready = NUM_REQ'(ad_hs) << g;
  assign req_alpha_data = finder_output_data;
  assign req_alpha_valid = NUM_REQ'(finder_output_valid && !tag_empty) << head;
  assign finder_output_ready = !tag_empty && req_alpha_ready[head];
  assign out_hs = finder_output_valid && finder_output_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      g <= '0;
      rr_ptr <= '0;
      an_sent <= 1'b0;
      ad_sent <= 1'b0;
    end else if (state == IDLE) begin
      if (grant) begin
        state <= SEND;
        g <= sel;
        an_sent <= 1'b0;
        ad_sent <= 1'b0;
      end
    end else begin
      an_sent <= an_done;
      ad_sent <= ad_done;
      if (an_done && ad_done) begin
        state <= IDLE;
        rr_ptr <= g == TW'(NUM_REQ - 1) ? '0 : g + 1'b1;
      end
    end
  end
  alpha_tag_fifo #(.W(TW), .DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk(clk),
    .rst(rst),
    .push(grant),
    .din(sel),
    .pop(out_hs),
    .dout(head),
    .full(tag_full),
    .empty(tag_empty),
    .count(tag_count)
  );
endmodule
